score_bar_sequencer: RTL and testbench
======================================

Name: score_bar_sequencer

Overview:
- Upstream stage of the score-bar drawer. Turns game-level score events (word typed correctly, game restart) into one-cycle plot and clear requests. Issues those requests only while the drawer reports ready.
- Queues increments that arrive while the drawer is busy, tracks drawn segments against the bar capacity, and keeps a binary score for the HUD.

Parameters:
- MAX_SEGMENTS, 29, number of 10-pixel segments the bar can hold; increments beyond this update the score only.
- PEND_W, 4, width of the pending-increment counter; it saturates at 2^PEND_W-1.
- SCORE_W, 10, width of the score counter; it saturates at 2^SCORE_W-1.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous reset, active-low
- word_correct  in  1  one-cycle pulse, score +1
- game_restart  in  1  one-cycle pulse, zero score and clear bar
- ready_to_plot_scorebar  in  1  drawer idle (level)
- enable_plot_scorebar  out  1  one-cycle request to draw next segment
- enable_clear_scorebar  out  1  one-cycle request to clear bar
- score  out  SCORE_W  current score
- segments  out  5  segments drawn or committed, 0..MAX_SEGMENTS
- pending  out  PEND_W  queued segment draws not yet issued
- bar_full  out  1  segments == MAX_SEGMENTS
- busy  out  1  request in flight (not S_IDLE)

Behaviour:
- Reset (async, resetn=0): state S_CLEAR_REQ. score=0, segments=0, pending=0, enable_plot_scorebar=0, enable_clear_scorebar=0, bar_full=0. Busy is asserted because the state is not S_IDLE.
- Reset release: the bar is cleared once via the normal clear path.
- Outputs are registered. Each request pulse is exactly 1 cycle, asserted the cycle after the FSM decides.
- States:
  - S_IDLE. If clear_flag=1 and ready=1, go to S_CLEAR_REQ. Else if pending>0 and ready=1, go to S_PLOT_REQ. Else stay.
  - S_PLOT_REQ. enable_plot_scorebar=1 for this cycle. pending decrements and segments increments here. Go to S_WAIT_BUSY.
  - S_CLEAR_REQ. enable_clear_scorebar=1 for this cycle. Go to S_WAIT_BUSY.
  - S_WAIT_BUSY. Wait for ready=0, meaning the drawer accepted the request, then go to S_WAIT_READY. If ready stays 1 for 4 cycles, go back to S_IDLE and reissue the lost request: restore pending and segments for a plot, or keep clear_flag for a clear.
  - S_WAIT_READY. Wait for ready=1, then go to S_IDLE.
  - The S_WAIT_BUSY / S_WAIT_READY handshake means a request is never issued twice against the same ready window.
- clear_flag: set by game_restart and by reset release. Cleared in S_CLEAR_REQ.
- word_correct handling:
  - score += 1, saturating.
  - If segments + pending < MAX_SEGMENTS and pending is not saturated, pending += 1. Otherwise the event updates the score only.
- game_restart handling:
  - score=0 and pending=0 in the same cycle; segments=0 when S_CLEAR_REQ issues.
  - An in-flight plot completes normally before the clear is issued.
- Simultaneous events in one cycle:
  - word_correct and game_restart together: restart wins and the word event is dropped.
  - word_correct and the S_PLOT_REQ decrement together: pending net change is 0.
- Ordering: a queued clear always precedes any queued plot. Plots issued after a clear start again from segment 0.
- bar_full is combinational from the segments register, so it has no extra latency.
- Minimum latency, word_correct pulse at cycle t with the drawer ready and the FSM idle:
  - t+1: pending=1.
  - t+2: FSM in S_PLOT_REQ.
  - t+2: enable_plot_scorebar high on the registered output.

Decomposition:
- Shared package: state encodings (S_IDLE=0, S_PLOT_REQ=1, S_CLEAR_REQ=2, S_WAIT_BUSY=3, S_WAIT_READY=4), BAR_SEGMENT_PX=10, BAR_X0=10, BAR_Y0=44, MAX_SEGMENTS.
- One sub-module, score_event_counter: the saturating score and pending counters with simultaneous increment/decrement. The FSM stays in the top.

Test Plan:
- Reset then hold ready=1 -> one enable_clear_scorebar pulse, then idle. Check score=0, segments=0, pending=0.
- With ready=1 and idle, pulse word_correct once -> enable_plot_scorebar high at t+2 for exactly 1 cycle. Then score=1 and segments=1.
- Hold ready=0, pulse word_correct 3 times, then release ready with ready dropping 2 cycles after each plot pulse -> exactly 3 plot pulses with the handshake respected. Final segments=3, pending=0, score=3.
- Issue 35 word_correct pulses with the drawer responsive -> exactly 29 plot pulses. Check score=35, bar_full=1, pending=0.
- With pending=2 and ready=0, pulse game_restart -> pending=0 and score=0. Once ready, one clear pulse and no plot pulses. Then segments=0.
- Hold ready=1 permanently after a plot pulse -> the timeout returns the FSM to S_IDLE and reissues the plot. Net segments change is +1 (no double count).

Source files
------------

// File: rtl/score_bar_sequencer_pkg.sv
// Shared constants for the score-bar sequencer: FSM encodings and bar geometry.
package score_bar_sequencer_pkg;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_PLOT_REQ   = 3'd1;
  localparam logic [2:0] S_CLEAR_REQ  = 3'd2;
  localparam logic [2:0] S_WAIT_BUSY  = 3'd3;
  localparam logic [2:0] S_WAIT_READY = 3'd4;

  localparam int BAR_SEGMENT_PX = 10;
  localparam int BAR_X0         = 10;
  localparam int BAR_Y0         = 44;
  localparam int MAX_SEGMENTS   = 29;

  // Right-hand pixel column of the bar after n segments have been drawn.
  function automatic int seg_x_right(input logic [4:0] n);
    return BAR_X0 + int'(n) * BAR_SEGMENT_PX;
  endfunction

endpackage

// File: rtl/score_bar_sequencer_event_counter.sv
// Saturating score counter and pending-plot counter. The pending counter
// accepts an increment, a restore and a decrement in the same cycle and
// resolves them into one net update; restart overrides everything.
module score_event_counter #(
  parameter int PEND_W  = 4,
  parameter int SCORE_W = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_score_inc,
  input  logic               i_restart,
  input  logic               i_pend_inc,
  input  logic               i_pend_dec,
  input  logic               i_pend_restore,
  output logic [SCORE_W-1:0] o_score,
  output logic [PEND_W-1:0]  o_pending
);

  localparam logic [PEND_W+1:0] PEND_MAX_X = {2'b00, {PEND_W{1'b1}}};

  logic [SCORE_W-1:0] r_score;
  logic [PEND_W-1:0]  r_pending;
  logic [PEND_W+1:0]  w_pend_sum;
  logic [PEND_W-1:0]  w_pend_next;

  // Net pending update in a wider domain, clamped at zero and at full scale.
  always_comb begin
    w_pend_sum = {2'b00, r_pending} + (PEND_W+2)'(i_pend_inc) + (PEND_W+2)'(i_pend_restore);
    if (i_pend_dec && (w_pend_sum != '0)) w_pend_sum = w_pend_sum - (PEND_W+2)'(1);
    w_pend_next = (w_pend_sum > PEND_MAX_X) ? {PEND_W{1'b1}} : w_pend_sum[PEND_W-1:0];
  end

  // Score and pending registers; restart zeroes both.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_score   <= '0;
      r_pending <= '0;
    end else if (i_restart) begin
      r_score   <= '0;
      r_pending <= '0;
    end else begin
      if (i_score_inc && (r_score != {SCORE_W{1'b1}})) r_score <= r_score + SCORE_W'(1);
      r_pending <= w_pend_next;
    end
  end

  assign o_score   = r_score;
  assign o_pending = r_pending;

endmodule

// File: rtl/score_bar_sequencer.sv
// Score-bar sequencer: turns score events into one-cycle plot/clear requests
// for the drawer, using a two-phase ready handshake (wait for ready to drop,
// then to rise) so a request is never issued twice in one ready window.
// A request that the drawer never acknowledges (ready stays high for four
// cycles) is rolled back and reissued from S_IDLE.
module score_bar_sequencer #(
  parameter int MAX_SEGMENTS = score_bar_sequencer_pkg::MAX_SEGMENTS,
  parameter int PEND_W       = 4,
  parameter int SCORE_W      = 10
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               word_correct,
  input  logic               game_restart,
  input  logic               ready_to_plot_scorebar,
  output logic               enable_plot_scorebar,
  output logic               enable_clear_scorebar,
  output logic [SCORE_W-1:0] score,
  output logic [4:0]         segments,
  output logic [PEND_W-1:0]  pending,
  output logic               bar_full,
  output logic               busy,
  output logic [2:0]         o_dbg_state
);
  import score_bar_sequencer_pkg::*;

  localparam int CW = ((PEND_W > 5) ? PEND_W : 5) + 1;
  localparam logic [PEND_W-1:0] PEND_MAX = {PEND_W{1'b1}};

  logic [2:0]        r_state;
  logic [2:0]        w_next;
  logic              r_en_plot;
  logic              r_en_clear;
  logic              r_clear_flag;
  logic              r_req_plot;
  logic [1:0]        r_wait_cnt;
  logic [4:0]        r_segments;
  logic [PEND_W-1:0] w_pending;
  logic [CW-1:0]     w_committed;
  logic              w_ready;
  logic              w_timeout;
  logic              w_pend_dec;
  logic              w_pend_restore;
  logic              w_clear_issue;
  logic              w_pend_room;
  logic              w_accept;
  logic              w_score_inc;

  assign w_ready        = ready_to_plot_scorebar;
  assign w_timeout      = (r_state == S_WAIT_BUSY) && w_ready && (r_wait_cnt == 2'd3);
  assign w_pend_dec     = (r_state == S_PLOT_REQ);
  assign w_pend_restore = w_timeout && r_req_plot;
  // The reset state S_CLEAR_REQ carries no pulse; only a pulsed visit counts.
  assign w_clear_issue  = (r_state == S_CLEAR_REQ) && r_en_clear;
  assign w_committed    = CW'(r_segments) + CW'(w_pending);
  assign w_pend_room    = w_pend_restore ? (w_pending < (PEND_MAX - PEND_W'(1))) : (w_pending != PEND_MAX);
  assign w_score_inc    = word_correct && !game_restart;
  assign w_accept       = w_score_inc && w_pend_room && (w_committed < CW'(MAX_SEGMENTS));

  score_event_counter #(
    .PEND_W  (PEND_W),
    .SCORE_W (SCORE_W)
  ) u_counter (
    .clk            (clk),
    .rst_n          (resetn),
    .i_score_inc    (w_score_inc),
    .i_restart      (game_restart),
    .i_pend_inc     (w_accept),
    .i_pend_dec     (w_pend_dec),
    .i_pend_restore (w_pend_restore),
    .o_score        (score),
    .o_pending      (w_pending)
  );

  // Next-state decision; a queued clear always wins over a queued plot.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_ready && r_clear_flag)            w_next = S_CLEAR_REQ;
        else if (w_ready && (w_pending != '0))  w_next = S_PLOT_REQ;
      end
      S_PLOT_REQ:   w_next = S_WAIT_BUSY;
      S_CLEAR_REQ:  w_next = r_en_clear ? S_WAIT_BUSY : S_IDLE;
      S_WAIT_BUSY: begin
        if (!w_ready)                 w_next = S_WAIT_READY;
        else if (r_wait_cnt == 2'd3)  w_next = S_IDLE;
      end
      S_WAIT_READY: if (w_ready) w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

  // State register and request pulses registered alongside entry to the request states.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_CLEAR_REQ;
      r_en_plot  <= 1'b0;
      r_en_clear <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_en_plot  <= (w_next == S_PLOT_REQ);
      r_en_clear <= (w_next == S_CLEAR_REQ);
    end
  end

  // Handshake bookkeeping: acknowledge timer, request kind and clear flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wait_cnt   <= 2'd0;
      r_req_plot   <= 1'b0;
      r_clear_flag <= 1'b1;
    end else begin
      if ((r_state == S_WAIT_BUSY) && w_ready) r_wait_cnt <= r_wait_cnt + 2'd1;
      else                                     r_wait_cnt <= 2'd0;
      if (r_state == S_PLOT_REQ)       r_req_plot <= 1'b1;
      else if (r_state == S_CLEAR_REQ) r_req_plot <= 1'b0;
      if (game_restart || (w_timeout && !r_req_plot)) r_clear_flag <= 1'b1;
      else if (w_clear_issue)                         r_clear_flag <= 1'b0;
    end
  end

  // Committed segment count: zeroed by an issued clear, rolled back on a lost plot.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_segments <= 5'd0;
    end else if (w_clear_issue) begin
      r_segments <= 5'd0;
    end else if (w_pend_dec) begin
      if (r_segments != 5'(MAX_SEGMENTS)) r_segments <= r_segments + 5'd1;
    end else if (w_pend_restore && (r_segments != 5'd0)) begin
      r_segments <= r_segments - 5'd1;
    end
  end

  assign enable_plot_scorebar  = r_en_plot;
  assign enable_clear_scorebar = r_en_clear;
  assign segments              = r_segments;
  assign pending               = w_pending;
  assign bar_full              = (r_segments == 5'(MAX_SEGMENTS));
  assign busy                  = (r_state != S_IDLE);
  assign o_dbg_state           = r_state;

endmodule

// File: tb/tb_score_bar_sequencer.sv
// Directed bench for score_bar_sequencer with a small drawer model that
// drops ready after each request for a programmable time.
module tb_score_bar_sequencer;

  logic       clk = 1'b0;
  logic       resetn;
  logic       word_correct;
  logic       game_restart;
  logic       ready_to_plot_scorebar;
  logic       enable_plot_scorebar;
  logic       enable_clear_scorebar;
  logic [9:0] score;
  logic [4:0] segments;
  logic [3:0] pending;
  logic       bar_full;
  logic       busy;
  logic [2:0] o_dbg_state;

  int total = 0;
  int bad   = 0;
  int plot_cnt  = 0;
  int clear_cnt = 0;
  // drawer model controls
  bit   drawer_auto = 1'b1;
  logic base_ready  = 1'b1;
  int   drop_delay  = 0;
  int   busy_len    = 2;
  int   dly = 0;
  int   low = 0;

  score_bar_sequencer dut (
    .clk                    (clk),
    .resetn                 (resetn),
    .word_correct           (word_correct),
    .game_restart           (game_restart),
    .ready_to_plot_scorebar (ready_to_plot_scorebar),
    .enable_plot_scorebar   (enable_plot_scorebar),
    .enable_clear_scorebar  (enable_clear_scorebar),
    .score                  (score),
    .segments               (segments),
    .pending                (pending),
    .bar_full               (bar_full),
    .busy                   (busy),
    .o_dbg_state            (o_dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One clock: sample after the edge, count pulses, update the drawer's ready.
  task automatic tick();
    @(posedge clk);
    #1;
    if (enable_plot_scorebar === 1'b1)  plot_cnt++;
    if (enable_clear_scorebar === 1'b1) clear_cnt++;
    if (drawer_auto && (enable_plot_scorebar === 1'b1 || enable_clear_scorebar === 1'b1)) begin
      dly = drop_delay;
      low = busy_len;
    end
    if (dly > 0) begin
      dly--;
      ready_to_plot_scorebar = 1'b1;
    end else if (low > 0) begin
      low--;
      ready_to_plot_scorebar = 1'b0;
    end else begin
      ready_to_plot_scorebar = base_ready;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_word();
    word_correct = 1'b1;
    tick();
    word_correct = 1'b0;
  endtask

  task automatic restart_settle();
    game_restart = 1'b1;
    tick();
    game_restart = 1'b0;
    ticks(12);
  endtask

  initial begin
    resetn = 1'b0;
    word_correct = 1'b0;
    game_restart = 1'b0;
    ready_to_plot_scorebar = 1'b1;

    // reset values
    ticks(2);
    check("rst_state", 32'(o_dbg_state), 2);
    check("rst_score", 32'(score), 0);
    check("rst_segments", 32'(segments), 0);
    check("rst_pending", 32'(pending), 0);
    check("rst_en_plot", 32'(enable_plot_scorebar), 0);
    check("rst_en_clear", 32'(enable_clear_scorebar), 0);
    check("rst_bar_full", 32'(bar_full), 0);
    check("rst_busy", 32'(busy), 1);

    // reset release: one clear through the normal path, then idle
    resetn = 1'b1;
    plot_cnt = 0; clear_cnt = 0;
    ticks(15);
    check("init_clear_pulses", 32'(clear_cnt), 1);
    check("init_plot_pulses", 32'(plot_cnt), 0);
    check("init_state", 32'(o_dbg_state), 0);
    check("init_busy", 32'(busy), 0);
    check("init_segments", 32'(segments), 0);
    check("init_pending", 32'(pending), 0);

    // minimum latency of a single word
    plot_cnt = 0; clear_cnt = 0;
    pulse_word();
    check("lat_t1_pending", 32'(pending), 1);
    check("lat_t1_en_plot", 32'(enable_plot_scorebar), 0);
    tick();
    check("lat_t2_state", 32'(o_dbg_state), 1);
    check("lat_t2_en_plot", 32'(enable_plot_scorebar), 1);
    tick();
    check("lat_t3_en_plot", 32'(enable_plot_scorebar), 0);
    ticks(8);
    check("lat_plot_pulses", 32'(plot_cnt), 1);
    check("lat_score", 32'(score), 1);
    check("lat_segments", 32'(segments), 1);

    // three words queued while busy, then released with a late-dropping drawer
    restart_settle();
    check("rs1_segments", 32'(segments), 0);
    check("rs1_score", 32'(score), 0);
    base_ready = 1'b0;
    ready_to_plot_scorebar = 1'b0;
    plot_cnt = 0; clear_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      pulse_word();
      tick();
    end
    check("q3_pending", 32'(pending), 3);
    check("q3_no_plot_yet", 32'(plot_cnt), 0);
    drop_delay = 2;
    base_ready = 1'b1;
    ready_to_plot_scorebar = 1'b1;
    ticks(40);
    check("q3_plot_pulses", 32'(plot_cnt), 3);
    check("q3_segments", 32'(segments), 3);
    check("q3_pending_end", 32'(pending), 0);
    check("q3_score", 32'(score), 3);
    drop_delay = 0;

    // 35 words with a responsive drawer: bar caps at 29 segments
    restart_settle();
    plot_cnt = 0; clear_cnt = 0;
    for (int i = 0; i < 35; i++) begin
      pulse_word();
      ticks(4);
    end
    ticks(30);
    check("cap_plot_pulses", 32'(plot_cnt), 29);
    check("cap_score", 32'(score), 35);
    check("cap_bar_full", 32'(bar_full), 1);
    check("cap_segments", 32'(segments), 29);
    check("cap_pending", 32'(pending), 0);

    // restart with pending work and the drawer busy
    restart_settle();
    check("rs2_bar_full", 32'(bar_full), 0);
    for (int i = 0; i < 2; i++) begin
      pulse_word();
      ticks(5);
    end
    ticks(10);
    check("pre_rs_segments", 32'(segments), 2);
    base_ready = 1'b0;
    ready_to_plot_scorebar = 1'b0;
    tick();
    pulse_word();
    pulse_word();
    check("pre_rs_pending", 32'(pending), 2);
    plot_cnt = 0; clear_cnt = 0;
    word_correct = 1'b1;
    game_restart = 1'b1;
    tick();
    word_correct = 1'b0;
    game_restart = 1'b0;
    check("rs_pending", 32'(pending), 0);
    check("rs_score_word_dropped", 32'(score), 0);
    check("rs_segments_held", 32'(segments), 2);
    base_ready = 1'b1;
    ready_to_plot_scorebar = 1'b1;
    ticks(15);
    check("rs_clear_pulses", 32'(clear_cnt), 1);
    check("rs_plot_pulses", 32'(plot_cnt), 0);
    check("rs_segments", 32'(segments), 0);

    // lost plot: drawer never drops ready, request is rolled back and reissued
    drawer_auto = 1'b0;
    plot_cnt = 0; clear_cnt = 0;
    pulse_word();
    ticks(6);
    check("to_state_idle", 32'(o_dbg_state), 0);
    check("to_pending_restored", 32'(pending), 1);
    check("to_segments_restored", 32'(segments), 0);
    check("to_first_pulse", 32'(plot_cnt), 1);
    drawer_auto = 1'b1;
    busy_len = 2;
    tick();
    check("to_reissue_state", 32'(o_dbg_state), 1);
    check("to_reissue_en", 32'(enable_plot_scorebar), 1);
    ticks(10);
    check("to_plot_pulses", 32'(plot_cnt), 2);
    check("to_segments", 32'(segments), 1);
    check("to_pending", 32'(pending), 0);
    check("to_score", 32'(score), 1);
    check("to_idle", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
